dcache_mshr_file: RTL and testbench

Parametrised, out-of-order miss-status holding register file for the D-cache controller. Replaces the in-order issue/response MSHR pair with NUM_ENTRIES fully associative entries, each with its own state machine, entry-ID-tagged bus responses, same-line request merging, GET_S→GET_M upgrade, and snoop-driven fill suppression. It sits between the load/store miss path and the coherent bus, and drives the cachemem fill port.

---
 rtl/dcache_mshr_file_if.sv | 86 ++++++++
 rtl/dcache_mshr_file.sv | 202 ++++++++++++++++++++
 tb/tb_dcache_mshr_file.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mshr_file_if.sv
// Shared message type and the bundled alloc/lookup/bus/snoop/fill signals of the
// D-cache MSHR file. The MSHR itself sits on the slave modport.
`ifndef DCACHE_TAG_W
`define DCACHE_TAG_W 8
`endif
`ifndef DCACHE_IDX_W
`define DCACHE_IDX_W 4
`endif
`ifndef DCACHE_WORD_IN_BITS
`define DCACHE_WORD_IN_BITS 32
`endif

package dcache_mshr_pkg;
   typedef enum logic [1:0] {NONE = 2'd0, GET_S = 2'd1, GET_M = 2'd2, PUT_M = 2'd3} message_t;
endpackage

interface dcache_mshr_file_if #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = `DCACHE_TAG_W,
   parameter int IDX_W       = `DCACHE_IDX_W,
   parameter int DATA_W      = `DCACHE_WORD_IN_BITS,
   parameter int EID_W       = $clog2(NUM_ENTRIES),
   parameter int MERGE_W     = 3
) ();
   logic                       cpu_id_i;
   logic                       alloc_en_i;
   logic [TAG_W-1:0]           alloc_tag_i;
   logic [IDX_W-1:0]           alloc_idx_i;
   logic [DATA_W-1:0]          alloc_data_i;
   dcache_mshr_pkg::message_t  alloc_message_i;
   logic                       alloc_ack_o;
   logic                       alloc_merge_o;
   logic [EID_W-1:0]           alloc_eid_o;
   logic [TAG_W-1:0]           lkup_tag_i;
   logic [IDX_W-1:0]           lkup_idx_i;
   logic                       lkup_hit_o;
   logic                       lkup_data_vld_o;
   logic [DATA_W-1:0]          lkup_data_o;
   logic                       req_en_o;
   logic [TAG_W-1:0]           req_tag_o;
   logic [IDX_W-1:0]           req_idx_o;
   logic [DATA_W-1:0]          req_data_o;
   dcache_mshr_pkg::message_t  req_message_o;
   logic [EID_W-1:0]           req_eid_o;
   logic                       req_ack_i;
   logic                       rsp_vld_i;
   logic                       rsp_id_i;
   logic [EID_W-1:0]           rsp_eid_i;
   logic [DATA_W-1:0]          rsp_data_i;
   logic                       rsp_ack_o;
   logic                       snp_vld_i;
   logic                       snp_id_i;
   logic [TAG_W-1:0]           snp_tag_i;
   logic [IDX_W-1:0]           snp_idx_i;
   dcache_mshr_pkg::message_t  snp_message_i;
   logic                       fill_en_o;
   logic [TAG_W-1:0]           fill_tag_o;
   logic [IDX_W-1:0]           fill_idx_o;
   logic [DATA_W-1:0]          fill_data_o;
   dcache_mshr_pkg::message_t  fill_message_o;
   logic                       fill_install_o;
   logic [MERGE_W-1:0]         fill_ld_cnt_o;
   logic                       fill_ready_i;
   logic                       full_o;
   logic                       empty_o;

   modport slave (
      input  cpu_id_i, alloc_en_i, alloc_tag_i, alloc_idx_i, alloc_data_i, alloc_message_i,
             lkup_tag_i, lkup_idx_i, req_ack_i, rsp_vld_i, rsp_id_i, rsp_eid_i, rsp_data_i,
             snp_vld_i, snp_id_i, snp_tag_i, snp_idx_i, snp_message_i, fill_ready_i,
      output alloc_ack_o, alloc_merge_o, alloc_eid_o, lkup_hit_o, lkup_data_vld_o, lkup_data_o,
             req_en_o, req_tag_o, req_idx_o, req_data_o, req_message_o, req_eid_o, rsp_ack_o,
             fill_en_o, fill_tag_o, fill_idx_o, fill_data_o, fill_message_o, fill_install_o,
             fill_ld_cnt_o, full_o, empty_o
   );

   modport master (
      output cpu_id_i, alloc_en_i, alloc_tag_i, alloc_idx_i, alloc_data_i, alloc_message_i,
             lkup_tag_i, lkup_idx_i, req_ack_i, rsp_vld_i, rsp_id_i, rsp_eid_i, rsp_data_i,
             snp_vld_i, snp_id_i, snp_tag_i, snp_idx_i, snp_message_i, fill_ready_i,
      input  alloc_ack_o, alloc_merge_o, alloc_eid_o, lkup_hit_o, lkup_data_vld_o, lkup_data_o,
             req_en_o, req_tag_o, req_idx_o, req_data_o, req_message_o, req_eid_o, rsp_ack_o,
             fill_en_o, fill_tag_o, fill_idx_o, fill_data_o, fill_message_o, fill_install_o,
             fill_ld_cnt_o, full_o, empty_o
   );
endinterface

// File: rtl/dcache_mshr_file.sv
// Out-of-order, fully associative MSHR file: same-line merging, GET_S->GET_M upgrade,
// round-robin bus issue, entry-ID tagged responses and snoop-driven fill suppression.
module dcache_mshr_file
   import dcache_mshr_pkg::*;
#(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = `DCACHE_TAG_W,
   parameter int IDX_W       = `DCACHE_IDX_W,
   parameter int DATA_W      = `DCACHE_WORD_IN_BITS,
   parameter int EID_W       = $clog2(NUM_ENTRIES),
   parameter int MERGE_W     = 3
) (
   input logic               clk,
   input logic               rst,
   dcache_mshr_file_if.slave bus
);
   typedef enum logic [1:0] {ST_INVALID, ST_PEND, ST_WAIT, ST_FILL} state_t;

   state_t             state_q  [NUM_ENTRIES];
   state_t             state_d  [NUM_ENTRIES];
   logic [TAG_W-1:0]   tag_q    [NUM_ENTRIES];
   logic [TAG_W-1:0]   tag_d    [NUM_ENTRIES];
   logic [IDX_W-1:0]   idx_q    [NUM_ENTRIES];
   logic [IDX_W-1:0]   idx_d    [NUM_ENTRIES];
   logic [DATA_W-1:0]  data_q   [NUM_ENTRIES];
   logic [DATA_W-1:0]  data_d   [NUM_ENTRIES];
   message_t           msg_q    [NUM_ENTRIES];
   message_t           msg_d    [NUM_ENTRIES];
   logic [MERGE_W-1:0] ld_cnt_q [NUM_ENTRIES];
   logic [MERGE_W-1:0] ld_cnt_d [NUM_ENTRIES];
   logic               stale_q  [NUM_ENTRIES];
   logic               stale_d  [NUM_ENTRIES];
   logic [EID_W-1:0]   rr_q, rr_d;

   logic             full, empty, free_vld, match_vld, lkup_hit, fill_vld, sel_vld;
   logic [EID_W-1:0] free_eid, match_eid, lkup_eid, fill_eid, sel_eid;
   logic             issue, rsp_hit, acked_here, m_pend, m_wait;
   logic             ack, merge;
   logic [EID_W-1:0] ack_eid;

   // Descending loops leave the lowest qualifying index as the winner.
   always_comb begin
      full      = 1'b1;
      empty     = 1'b1;
      free_vld  = 1'b0;
      free_eid  = '0;
      match_vld = 1'b0;
      match_eid = '0;
      lkup_hit  = 1'b0;
      lkup_eid  = '0;
      fill_vld  = 1'b0;
      fill_eid  = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (state_q[i] == ST_INVALID) begin
            full     = 1'b0;
            free_vld = 1'b1;
            free_eid = EID_W'(i);
         end else begin
            empty = 1'b0;
            if (tag_q[i] == bus.alloc_tag_i && idx_q[i] == bus.alloc_idx_i) begin
               match_vld = 1'b1;
               match_eid = EID_W'(i);
            end
            if (tag_q[i] == bus.lkup_tag_i && idx_q[i] == bus.lkup_idx_i) begin
               lkup_hit = 1'b1;
               lkup_eid = EID_W'(i);
            end
         end
         if (state_q[i] == ST_FILL) begin
            fill_vld = 1'b1;
            fill_eid = EID_W'(i);
         end
      end
      sel_vld = 1'b0;
      sel_eid = '0;
      for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
         if (state_q[rr_q + EID_W'(k)] == ST_PEND) begin
            sel_vld = 1'b1;
            sel_eid = rr_q + EID_W'(k);
         end
      end
   end

   // An entry being acked onto the bus this cycle is treated as already WAIT when merging.
   always_comb begin
      issue      = sel_vld && bus.req_ack_i;
      rsp_hit    = bus.rsp_vld_i && (bus.rsp_id_i == bus.cpu_id_i) && (state_q[bus.rsp_eid_i] == ST_WAIT);
      acked_here = issue && (sel_eid == match_eid);
      m_pend     = (state_q[match_eid] == ST_PEND) && !acked_here;
      m_wait     = (state_q[match_eid] == ST_WAIT) || ((state_q[match_eid] == ST_PEND) && acked_here);
      ack        = 1'b0;
      merge      = 1'b0;
      ack_eid    = '0;
      if (bus.alloc_en_i && (bus.alloc_message_i == GET_S || bus.alloc_message_i == GET_M)) begin
         if (match_vld) begin
            if ((bus.alloc_message_i == GET_S && (m_pend || m_wait)) ||
                (bus.alloc_message_i == GET_M && m_pend) ||
                (bus.alloc_message_i == GET_M && m_wait && msg_q[match_eid] == GET_M)) begin
               ack     = 1'b1;
               merge   = 1'b1;
               ack_eid = match_eid;
            end
         end else if (free_vld) begin
            ack     = 1'b1;
            ack_eid = free_eid;
         end
      end
   end

   // Later assignments win: fill release, then alloc writes over response data.
   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      idx_d    = idx_q;
      data_d   = data_q;
      msg_d    = msg_q;
      ld_cnt_d = ld_cnt_q;
      stale_d  = stale_q;
      rr_d     = rr_q;
      if (issue) begin
         state_d[sel_eid] = ST_WAIT;
         rr_d             = sel_eid + EID_W'(1);
      end
      if (rsp_hit) begin
         state_d[bus.rsp_eid_i] = ST_FILL;
         if (msg_q[bus.rsp_eid_i] != GET_M) data_d[bus.rsp_eid_i] = bus.rsp_data_i;
      end
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (bus.snp_vld_i && bus.snp_id_i != bus.cpu_id_i && bus.snp_message_i == GET_M &&
             state_q[i] == ST_WAIT && msg_q[i] == GET_S &&
             tag_q[i] == bus.snp_tag_i && idx_q[i] == bus.snp_idx_i)
            stale_d[i] = 1'b1;
      end
      if (fill_vld && bus.fill_ready_i) begin
         state_d[fill_eid] = ST_INVALID;
         stale_d[fill_eid] = 1'b0;
      end
      if (ack && merge) begin
         if (bus.alloc_message_i == GET_S) begin
            if (ld_cnt_q[ack_eid] != '1) ld_cnt_d[ack_eid] = ld_cnt_q[ack_eid] + MERGE_W'(1);
         end else begin
            msg_d[ack_eid]  = GET_M;
            data_d[ack_eid] = bus.alloc_data_i;
         end
      end else if (ack) begin
         state_d[ack_eid]  = ST_PEND;
         tag_d[ack_eid]    = bus.alloc_tag_i;
         idx_d[ack_eid]    = bus.alloc_idx_i;
         data_d[ack_eid]   = bus.alloc_data_i;
         msg_d[ack_eid]    = bus.alloc_message_i;
         ld_cnt_d[ack_eid] = (bus.alloc_message_i == GET_S) ? MERGE_W'(1) : '0;
         stale_d[ack_eid]  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_q[i]  <= ST_INVALID;
            tag_q[i]    <= '0;
            idx_q[i]    <= '0;
            data_q[i]   <= '0;
            msg_q[i]    <= NONE;
            ld_cnt_q[i] <= '0;
            stale_q[i]  <= 1'b0;
         end
         rr_q <= '0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         msg_q    <= msg_d;
         ld_cnt_q <= ld_cnt_d;
         stale_q  <= stale_d;
         rr_q     <= rr_d;
      end
   end

   assign bus.alloc_ack_o     = ack;
   assign bus.alloc_merge_o   = merge;
   assign bus.alloc_eid_o     = ack_eid;
   assign bus.lkup_hit_o      = lkup_hit;
   assign bus.lkup_data_vld_o = lkup_hit && (msg_q[lkup_eid] == GET_M);
   assign bus.lkup_data_o     = (lkup_hit && msg_q[lkup_eid] == GET_M) ? data_q[lkup_eid] : '0;
   assign bus.req_en_o        = sel_vld;
   assign bus.req_tag_o       = sel_vld ? tag_q[sel_eid] : '0;
   assign bus.req_idx_o       = sel_vld ? idx_q[sel_eid] : '0;
   assign bus.req_data_o      = sel_vld ? data_q[sel_eid] : '0;
   assign bus.req_message_o   = sel_vld ? msg_q[sel_eid] : NONE;
   assign bus.req_eid_o       = sel_eid;
   assign bus.rsp_ack_o       = rsp_hit;
   assign bus.fill_en_o       = fill_vld;
   assign bus.fill_tag_o      = fill_vld ? tag_q[fill_eid] : '0;
   assign bus.fill_idx_o      = fill_vld ? idx_q[fill_eid] : '0;
   assign bus.fill_data_o     = fill_vld ? data_q[fill_eid] : '0;
   assign bus.fill_message_o  = fill_vld ? msg_q[fill_eid] : NONE;
   assign bus.fill_install_o  = fill_vld && !stale_q[fill_eid];
   assign bus.fill_ld_cnt_o   = fill_vld ? ld_cnt_q[fill_eid] : '0;
   assign bus.full_o          = full;
   assign bus.empty_o         = empty;
endmodule

// File: tb/tb_dcache_mshr_file.sv
// Directed bench for dcache_mshr_file: inputs change on the falling edge and
// combinational outputs are sampled 1ns later.
module tb_dcache_mshr_file;
   import dcache_mshr_pkg::*;

   localparam int N  = 4;
   localparam int TW = 8;
   localparam int IW = 4;
   localparam int DW = 32;
   localparam int EW = 2;
   localparam int MW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   dcache_mshr_file_if #(.NUM_ENTRIES(N), .TAG_W(TW), .IDX_W(IW), .DATA_W(DW), .EID_W(EW), .MERGE_W(MW)) bus ();

   dcache_mshr_file #(.NUM_ENTRIES(N), .TAG_W(TW), .IDX_W(IW), .DATA_W(DW), .EID_W(EW), .MERGE_W(MW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic idle();
      bus.cpu_id_i = 1'b0;      bus.alloc_en_i = 1'b0;    bus.alloc_tag_i = '0;
      bus.alloc_idx_i = '0;     bus.alloc_data_i = '0;    bus.alloc_message_i = NONE;
      bus.lkup_tag_i = '0;      bus.lkup_idx_i = '0;      bus.req_ack_i = 1'b0;
      bus.rsp_vld_i = 1'b0;     bus.rsp_id_i = 1'b0;      bus.rsp_eid_i = '0;
      bus.rsp_data_i = '0;      bus.snp_vld_i = 1'b0;     bus.snp_id_i = 1'b0;
      bus.snp_tag_i = '0;       bus.snp_idx_i = '0;       bus.snp_message_i = NONE;
      bus.fill_ready_i = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      idle();
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic drive_alloc(input logic [TW-1:0] t, input logic [IW-1:0] x,
                              input logic [DW-1:0] d, input message_t m);
      bus.alloc_en_i = 1'b1; bus.alloc_tag_i = t; bus.alloc_idx_i = x;
      bus.alloc_data_i = d;  bus.alloc_message_i = m;
   endtask

   task automatic drive_rsp(input logic id, input logic [EW-1:0] e, input logic [DW-1:0] d);
      bus.rsp_vld_i = 1'b1; bus.rsp_id_i = id; bus.rsp_eid_i = e; bus.rsp_data_i = d;
   endtask

   task automatic test_reset();
      idle();
      #2 rst = 1'b0;
      #10;
      vectors++;
      if ({bus.empty_o, bus.full_o, bus.req_en_o, bus.fill_en_o, bus.rsp_ack_o, bus.alloc_ack_o} !== 6'b100000) begin
         $display("[TB] FAIL reset_flags: got %b want 100000",
                  {bus.empty_o, bus.full_o, bus.req_en_o, bus.fill_en_o, bus.rsp_ack_o, bus.alloc_ack_o});
         miscompares++;
      end
      vectors++;
      if (bus.req_message_o !== NONE || bus.fill_message_o !== NONE) begin
         $display("[TB] FAIL reset_msgs: got %0d/%0d want 0/0", bus.req_message_o, bus.fill_message_o);
         miscompares++;
      end
      step();
      rst = 1'b1;
   endtask

   task automatic test_full();
      reset_dut();
      for (int i = 0; i < N; i++) begin
         drive_alloc(TW'(8'h10 + i), IW'(i), DW'(32'h100 + i), GET_S);
         #1;
         vectors++;
         if ({bus.alloc_ack_o, bus.alloc_merge_o, bus.alloc_eid_o} !== {1'b1, 1'b0, EW'(i)}) begin
            $display("[TB] FAIL full_alloc%0d: got ack=%0b merge=%0b eid=%0d want 1 0 %0d",
                     i, bus.alloc_ack_o, bus.alloc_merge_o, bus.alloc_eid_o, i);
            miscompares++;
         end
         step();
      end
      drive_alloc(8'h20, 4'd0, 32'h0, GET_S);
      bus.lkup_tag_i = 8'h12; bus.lkup_idx_i = 4'd2;
      #1;
      vectors++;
      if ({bus.full_o, bus.empty_o, bus.alloc_ack_o} !== 3'b100) begin
         $display("[TB] FAIL full_stall: got full=%0b empty=%0b ack=%0b want 1 0 0",
                  bus.full_o, bus.empty_o, bus.alloc_ack_o);
         miscompares++;
      end
      vectors++;
      if ({bus.lkup_hit_o, bus.lkup_data_vld_o} !== 2'b10) begin
         $display("[TB] FAIL lkup_hit: got hit=%0b dvld=%0b want 1 0", bus.lkup_hit_o, bus.lkup_data_vld_o);
         miscompares++;
      end
      vectors++;
      if (bus.req_en_o !== 1'b1 || bus.req_eid_o !== 2'd0 || bus.req_tag_o !== 8'h10 || bus.req_message_o !== GET_S) begin
         $display("[TB] FAIL req_first: got en=%0b eid=%0d tag=%h msg=%0d want 1 0 10 1",
                  bus.req_en_o, bus.req_eid_o, bus.req_tag_o, bus.req_message_o);
         miscompares++;
      end
      bus.lkup_tag_i = 8'h99;
      #1;
      vectors++;
      if (bus.lkup_hit_o !== 1'b0) begin
         $display("[TB] FAIL lkup_miss: got %0b want 0", bus.lkup_hit_o);
         miscompares++;
      end
   endtask

   task automatic test_reset_mid();
      #2 rst = 1'b0;
      idle();
      #1;
      vectors++;
      if ({bus.empty_o, bus.full_o, bus.req_en_o, bus.fill_en_o} !== 4'b1000 || bus.req_message_o !== NONE) begin
         $display("[TB] FAIL reset_mid: got empty=%0b full=%0b req_en=%0b fill_en=%0b msg=%0d want 1 0 0 0 0",
                  bus.empty_o, bus.full_o, bus.req_en_o, bus.fill_en_o, bus.req_message_o);
         miscompares++;
      end
      step();
      rst = 1'b1;
   endtask

   task automatic test_merge();
      logic [2:0] exp [3];
      message_t   m   [3];
      exp[0] = 3'b100; exp[1] = 3'b110; exp[2] = 3'b110;
      m[0] = GET_S;    m[1] = GET_S;    m[2] = GET_M;
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         drive_alloc(8'h33, 4'd5, (i == 2) ? 32'hDEADBEEF : 32'h0, m[i]);
         #1;
         vectors++;
         if ({bus.alloc_ack_o, bus.alloc_merge_o, bus.alloc_eid_o[0]} !== exp[i]) begin
            $display("[TB] FAIL merge_alloc%0d: got %b want %b", i,
                     {bus.alloc_ack_o, bus.alloc_merge_o, bus.alloc_eid_o[0]}, exp[i]);
            miscompares++;
         end
         step();
      end
      idle();
      bus.lkup_tag_i = 8'h33; bus.lkup_idx_i = 4'd5;
      #1;
      vectors++;
      if (bus.req_message_o !== GET_M || bus.req_data_o !== 32'hDEADBEEF || bus.lkup_data_vld_o !== 1'b1 ||
          bus.lkup_data_o !== 32'hDEADBEEF) begin
         $display("[TB] FAIL merge_upgrade: got msg=%0d data=%h dvld=%0b ldata=%h want 2 deadbeef 1 deadbeef",
                  bus.req_message_o, bus.req_data_o, bus.lkup_data_vld_o, bus.lkup_data_o);
         miscompares++;
      end
      bus.req_ack_i = 1'b1;
      step();
      bus.req_ack_i = 1'b0;
      drive_rsp(1'b0, 2'd0, 32'h11111111);
      #1;
      vectors++;
      if (bus.rsp_ack_o !== 1'b1) begin
         $display("[TB] FAIL merge_rsp_ack: got %0b want 1", bus.rsp_ack_o);
         miscompares++;
      end
      step();
      bus.rsp_vld_i = 1'b0;
      #1;
      vectors++;
      if (bus.fill_en_o !== 1'b1 || bus.fill_data_o !== 32'hDEADBEEF || bus.fill_ld_cnt_o !== 3'd2 ||
          bus.fill_message_o !== GET_M || bus.fill_install_o !== 1'b1) begin
         $display("[TB] FAIL merge_fill: got en=%0b data=%h cnt=%0d msg=%0d inst=%0b want 1 deadbeef 2 2 1",
                  bus.fill_en_o, bus.fill_data_o, bus.fill_ld_cnt_o, bus.fill_message_o, bus.fill_install_o);
         miscompares++;
      end
      bus.fill_ready_i = 1'b1;
      step();
      bus.fill_ready_i = 1'b0;
      #1;
      vectors++;
      if (bus.empty_o !== 1'b1) begin
         $display("[TB] FAIL merge_freed: got empty=%0b want 1", bus.empty_o);
         miscompares++;
      end
   endtask

   task automatic test_ooo_rsp();
      logic [DW-1:0] fdat [3];
      logic [TW-1:0] ftag [3];
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         drive_alloc(TW'(8'h40 + i), IW'(i), 32'h0, GET_S);
         step();
      end
      idle();
      bus.req_ack_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (bus.req_en_o !== 1'b1 || bus.req_eid_o !== EW'(i)) begin
            $display("[TB] FAIL issue%0d: got en=%0b eid=%0d want 1 %0d", i, bus.req_en_o, bus.req_eid_o, i);
            miscompares++;
         end
         step();
      end
      bus.req_ack_i = 1'b0;
      drive_rsp(1'b0, 2'd3, 32'h33333333);
      #1;
      vectors++;
      if (bus.rsp_ack_o !== 1'b0 || bus.req_en_o !== 1'b0) begin
         $display("[TB] FAIL rsp_invalid: got ack=%0b req_en=%0b want 0 0", bus.rsp_ack_o, bus.req_en_o);
         miscompares++;
      end
      step();
      drive_rsp(1'b1, 2'd2, 32'hA2A2A2A2);
      #1;
      vectors++;
      if (bus.rsp_ack_o !== 1'b0) begin
         $display("[TB] FAIL rsp_other_cpu: got %0b want 0", bus.rsp_ack_o);
         miscompares++;
      end
      step();
      drive_rsp(1'b0, 2'd2, 32'hA2A2A2A2);
      step();
      drive_rsp(1'b0, 2'd0, 32'hA0A0A0A0);
      #1;
      vectors++;
      if (bus.fill_en_o !== 1'b1 || bus.fill_tag_o !== 8'h42 || bus.fill_data_o !== 32'hA2A2A2A2) begin
         $display("[TB] FAIL ooo_fill_first: got en=%0b tag=%h data=%h want 1 42 a2a2a2a2",
                  bus.fill_en_o, bus.fill_tag_o, bus.fill_data_o);
         miscompares++;
      end
      step();
      drive_rsp(1'b0, 2'd1, 32'hA1A1A1A1);
      bus.fill_ready_i = 1'b1;
      ftag[0] = 8'h40; ftag[1] = 8'h41; ftag[2] = 8'h42;
      fdat[0] = 32'hA0A0A0A0; fdat[1] = 32'hA1A1A1A1; fdat[2] = 32'hA2A2A2A2;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (bus.fill_en_o !== 1'b1 || bus.fill_tag_o !== ftag[i] || bus.fill_data_o !== fdat[i]) begin
            $display("[TB] FAIL ooo_fill%0d: got en=%0b tag=%h data=%h want 1 %h %h",
                     i, bus.fill_en_o, bus.fill_tag_o, bus.fill_data_o, ftag[i], fdat[i]);
            miscompares++;
         end
         step();
         bus.rsp_vld_i = 1'b0;
      end
      bus.fill_ready_i = 1'b0;
      #1;
      vectors++;
      if (bus.empty_o !== 1'b1) begin
         $display("[TB] FAIL ooo_drained: got empty=%0b want 1", bus.empty_o);
         miscompares++;
      end
   endtask

   task automatic test_snoop();
      reset_dut();
      drive_alloc(8'h12, 4'd3, 32'h0, GET_S);
      step();
      idle();
      bus.req_ack_i = 1'b1;
      step();
      bus.req_ack_i = 1'b0;
      bus.snp_vld_i = 1'b1; bus.snp_id_i = 1'b1; bus.snp_tag_i = 8'h12;
      bus.snp_idx_i = 4'd3; bus.snp_message_i = GET_M;
      step();
      bus.snp_vld_i = 1'b0;
      drive_rsp(1'b0, 2'd0, 32'h5A5A5A5A);
      step();
      bus.rsp_vld_i = 1'b0;
      #1;
      vectors++;
      if (bus.fill_en_o !== 1'b1 || bus.fill_install_o !== 1'b0 || bus.fill_data_o !== 32'h5A5A5A5A ||
          bus.fill_ld_cnt_o !== 3'd1) begin
         $display("[TB] FAIL snoop_stale: got en=%0b inst=%0b data=%h cnt=%0d want 1 0 5a5a5a5a 1",
                  bus.fill_en_o, bus.fill_install_o, bus.fill_data_o, bus.fill_ld_cnt_o);
         miscompares++;
      end
      bus.fill_ready_i = 1'b1;
      step();
      bus.fill_ready_i = 1'b0;
   endtask

   task automatic test_fill_stall();
      reset_dut();
      drive_alloc(8'h77, 4'd7, 32'hCAFEF00D, GET_M);
      step();
      idle();
      bus.req_ack_i = 1'b1;
      step();
      bus.req_ack_i = 1'b0;
      drive_rsp(1'b0, 2'd0, 32'h0);
      step();
      bus.rsp_vld_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++;
         if (bus.fill_en_o !== 1'b1 || bus.fill_data_o !== 32'hCAFEF00D || bus.fill_tag_o !== 8'h77 ||
             bus.fill_message_o !== GET_M || bus.fill_ld_cnt_o !== 3'd0) begin
            $display("[TB] FAIL fill_hold%0d: got en=%0b data=%h tag=%h msg=%0d cnt=%0d want 1 cafef00d 77 2 0",
                     i, bus.fill_en_o, bus.fill_data_o, bus.fill_tag_o, bus.fill_message_o, bus.fill_ld_cnt_o);
            miscompares++;
         end
         step();
      end
      bus.fill_ready_i = 1'b1;
      #1;
      vectors++;
      if (bus.fill_en_o !== 1'b1 || bus.empty_o !== 1'b0) begin
         $display("[TB] FAIL fill_ready_cycle: got en=%0b empty=%0b want 1 0", bus.fill_en_o, bus.empty_o);
         miscompares++;
      end
      step();
      bus.fill_ready_i = 1'b0;
      #1;
      vectors++;
      if (bus.fill_en_o !== 1'b0 || bus.empty_o !== 1'b1) begin
         $display("[TB] FAIL fill_released: got en=%0b empty=%0b want 0 1", bus.fill_en_o, bus.empty_o);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      reset_dut();
      drive_alloc(8'h55, 4'd1, 32'h0, GET_S);
      step();
      drive_alloc(8'h55, 4'd1, 32'h12345678, GET_M);
      bus.req_ack_i = 1'b1;
      #1;
      vectors++;
      if (bus.alloc_ack_o !== 1'b0) begin
         $display("[TB] FAIL race_upgrade_stall: got ack=%0b want 0", bus.alloc_ack_o);
         miscompares++;
      end
      step();
      bus.req_ack_i = 1'b0;
      drive_rsp(1'b0, 2'd0, 32'h00000077);
      #1;
      vectors++;
      if (bus.alloc_ack_o !== 1'b0 || bus.rsp_ack_o !== 1'b1) begin
         $display("[TB] FAIL wait_getm_stall: got ack=%0b rsp_ack=%0b want 0 1", bus.alloc_ack_o, bus.rsp_ack_o);
         miscompares++;
      end
      step();
      bus.rsp_vld_i = 1'b0;
      bus.alloc_message_i = GET_S;
      #1;
      vectors++;
      if (bus.fill_en_o !== 1'b1 || bus.fill_message_o !== GET_S || bus.fill_data_o !== 32'h77 ||
          bus.alloc_ack_o !== 1'b0) begin
         $display("[TB] FAIL b2b_fill: got en=%0b msg=%0d data=%h ack=%0b want 1 1 77 0",
                  bus.fill_en_o, bus.fill_message_o, bus.fill_data_o, bus.alloc_ack_o);
         miscompares++;
      end
      idle();
      bus.fill_ready_i = 1'b1;
      step();
      bus.fill_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full();
      test_reset_mid();
      test_merge();
      test_ooo_rsp();
      test_snoop();
      test_fill_stall();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
